bc_sched: RTL and testbench

Bus scheduler for the universal data bus connect. Each cycle it grants one bus slot to one of five requesters and drives the connect's two select fields. The requesters are the data-register-read (DRR) sources dg/ps/xb, plus dm and immediate (imm). DRR transfers pass through the connect's one-cycle PDR register, so the block also sequences that two-stage path and keeps direct sources from starving.

---
 rtl/bc_pkg.sv | 48 ++++
 rtl/bc_sched_rr3.sv | 50 +++++
 rtl/bc_sched.sv | 137 +++++++++++++
 tb/tb_bc_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// bc_pkg: shared encodings and helpers for the bus scheduler.
// Holds DRR/bus select codes, bus-slot owner codes and round-robin index math.
package bc_pkg;

    // Round-robin index over the three DRR sources: 0 dg, 1 ps, 2 xb.
    typedef logic [1:0] rr_idx_t;

    // DRR mux select (ps_bc_drr_sclt).
    localparam logic [1:0] DRR_DG   = 2'b00;
    localparam logic [1:0] DRR_PS   = 2'b01;
    localparam logic [1:0] DRR_XB   = 2'b10;
    localparam logic [1:0] DRR_NONE = 2'b11;

    // Bus select (ps_bc_di_sclt).
    localparam logic [1:0] DI_DM   = 2'b00;
    localparam logic [1:0] DI_PDR  = 2'b01;
    localparam logic [1:0] DI_IMM  = 2'b10;
    localparam logic [1:0] DI_IDLE = 2'b11;

    // Bus slot owner (bc_src).
    localparam logic [2:0] SRC_NONE = 3'd0;
    localparam logic [2:0] SRC_DG   = 3'd1;
    localparam logic [2:0] SRC_PS   = 3'd2;
    localparam logic [2:0] SRC_XB   = 3'd3;
    localparam logic [2:0] SRC_DM   = 3'd4;
    localparam logic [2:0] SRC_IMM  = 3'd5;

    // (a + b) mod 3 for indices in 0..2.
    function automatic rr_idx_t rr_add(input rr_idx_t a, input rr_idx_t b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    // Source following idx in the order dg -> ps -> xb -> dg.
    function automatic rr_idx_t rr_next(input rr_idx_t idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // DRR index to bus slot owner code.
    function automatic logic [2:0] rr_to_src(input rr_idx_t idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/bc_sched_rr3.sv
// bc_rr3: 3-way round-robin picker starting the search at ptr.
// Ports: req[2:0], ptr, en in; one-hot gnt[2:0] and next_ptr out.
module bc_rr3
    import bc_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       en,
    output logic [2:0] gnt,
    output logic [1:0] next_ptr
);

    // rot[k] is the request of source (ptr + k) mod 3.
    logic [2:0] rot;
    logic [1:0] off;
    rr_idx_t    sel;

    always_comb begin
        unique case (ptr)
            2'd1:    rot = {req[0], req[2], req[1]};
            2'd2:    rot = {req[1], req[0], req[2]};
            default: rot = req;
        endcase
    end

    always_comb begin
        off = 2'd2;
        if (rot[0]) begin
            off = 2'd0;
        end else if (rot[1]) begin
            off = 2'd1;
        end
    end

    assign sel = rr_add((ptr == 2'd3) ? 2'd0 : ptr, off);

    always_comb begin
        gnt      = 3'b000;
        next_ptr = ptr;
        if (en && (|req)) begin
            unique case (sel)
                2'd0:    gnt = 3'b001;
                2'd1:    gnt = 3'b010;
                default: gnt = 3'b100;
            endcase
            next_ptr = rr_next(sel);
        end
    end

endmodule

// File: rtl/bc_sched.sv
// bc_sched: bus slot scheduler for the universal data bus connect.
// Ports: clk_dcd, rst_n, bc_hold, five requests in; five grants, drr/di selects, bc_vld, bc_src out.
module bc_sched
    import bc_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic       clk_dcd,
    input  logic       rst_n,
    input  logic       bc_hold,
    input  logic       dg_req,
    input  logic       ps_req,
    input  logic       xb_req,
    input  logic       dm_req,
    input  logic       imm_req,
    output logic       dg_gnt,
    output logic       ps_gnt,
    output logic       xb_gnt,
    output logic       dm_gnt,
    output logic       imm_gnt,
    output logic [1:0] ps_bc_drr_sclt,
    output logic [1:0] ps_bc_di_sclt,
    output logic       bc_vld,
    output logic [2:0] bc_src
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic              pdr_vld;
    logic [2:0]        pdr_src;
    logic [1:0]        rr_ptr;
    logic [WAIT_W-1:0] wait_cnt;

    logic       dm_win;
    logic       imm_win;
    logic       dir_gnt;
    logic       dir_req;
    logic       starved;
    logic       inhibit;
    logic       drr_en;
    logic       drr_hit;
    logic [2:0] drr_req;
    logic [2:0] drr_gnt;
    logic [1:0] next_ptr;
    rr_idx_t    drr_idx;

    // Direct sources only get a slot that PDR has not already claimed.
    assign dm_win  = !pdr_vld && !bc_hold && dm_req;
    assign imm_win = !pdr_vld && !bc_hold && !dm_req && imm_req;
    assign dir_gnt = dm_win || imm_win;
    assign dir_req = dm_req || imm_req;

    // Inhibiting DRR frees the next slot. Once a direct source takes the
    // freed slot, DRR may refill the one after it.
    assign starved = (wait_cnt >= WAIT_MAX);
    assign inhibit = starved && !dir_gnt;
    assign drr_en  = !bc_hold && !inhibit;
    assign drr_req = {xb_req, ps_req, dg_req};

    bc_rr3 u_rr3 (
        .req      (drr_req),
        .ptr      (rr_ptr),
        .en       (drr_en),
        .gnt      (drr_gnt),
        .next_ptr (next_ptr)
    );

    assign drr_hit = |drr_gnt;

    always_comb begin
        drr_idx = 2'd0;
        unique case (1'b1)
            drr_gnt[1]: drr_idx = 2'd1;
            drr_gnt[2]: drr_idx = 2'd2;
            default:    drr_idx = 2'd0;
        endcase
    end

    // Outputs are forced quiet while reset is held low.
    always_comb begin
        dg_gnt         = 1'b0;
        ps_gnt         = 1'b0;
        xb_gnt         = 1'b0;
        dm_gnt         = 1'b0;
        imm_gnt        = 1'b0;
        ps_bc_drr_sclt = DRR_NONE;
        ps_bc_di_sclt  = DI_IDLE;
        bc_vld         = 1'b0;
        bc_src         = SRC_NONE;
        if (rst_n) begin
            dg_gnt  = drr_gnt[0];
            ps_gnt  = drr_gnt[1];
            xb_gnt  = drr_gnt[2];
            dm_gnt  = dm_win;
            imm_gnt = imm_win;
            if (drr_hit) begin
                ps_bc_drr_sclt = drr_idx;
            end
            if (pdr_vld) begin
                ps_bc_di_sclt = DI_PDR;
                bc_vld        = 1'b1;
                bc_src        = pdr_src;
            end else if (dm_win) begin
                ps_bc_di_sclt = DI_DM;
                bc_vld        = 1'b1;
                bc_src        = SRC_DM;
            end else if (imm_win) begin
                ps_bc_di_sclt = DI_IMM;
                bc_vld        = 1'b1;
                bc_src        = SRC_IMM;
            end
        end
    end

    always_ff @(posedge clk_dcd) begin
        if (!rst_n) begin
            pdr_vld  <= 1'b0;
            pdr_src  <= SRC_NONE;
            rr_ptr   <= 2'd0;
            wait_cnt <= '0;
        end else begin
            pdr_vld <= drr_hit;
            pdr_src <= drr_hit ? rr_to_src(drr_idx) : SRC_NONE;
            if (drr_hit) begin
                rr_ptr <= next_ptr;
            end
            // Counts only while a direct request is pending and unserved.
            if (dir_gnt || !dir_req) begin
                wait_cnt <= '0;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bc_sched.sv
// tb_bc_sched: directed and random checks of bc_sched against a slot-level model.
// Drives inputs after the rising edge and compares on the falling edge.
module tb_bc_sched;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 3;
    localparam int WAIT_SAT = (1 << WAIT_W) - 1;

    logic       clk_dcd = 1'b0;
    logic       rst_n   = 1'b0;
    logic       bc_hold = 1'b0;
    logic       dg_req  = 1'b0;
    logic       ps_req  = 1'b0;
    logic       xb_req  = 1'b0;
    logic       dm_req  = 1'b0;
    logic       imm_req = 1'b0;
    logic       dg_gnt, ps_gnt, xb_gnt, dm_gnt, imm_gnt;
    logic [1:0] ps_bc_drr_sclt, ps_bc_di_sclt;
    logic       bc_vld;
    logic [2:0] bc_src;

    logic [12:0] obs;
    logic [12:0] exp_v;

    int n_vec = 0;
    int n_err = 0;

    // Model state: owner code committed to the next slot, next DRR to favour, wait count.
    int   m_pdr = 0;
    int   m_rr  = 0;
    int   m_wt  = 0;
    int   m_g   = -1;
    logic m_dir = 1'b0;

    always #5 clk_dcd = ~clk_dcd;

    bc_sched #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
        .clk_dcd        (clk_dcd),
        .rst_n          (rst_n),
        .bc_hold        (bc_hold),
        .dg_req         (dg_req),
        .ps_req         (ps_req),
        .xb_req         (xb_req),
        .dm_req         (dm_req),
        .imm_req        (imm_req),
        .dg_gnt         (dg_gnt),
        .ps_gnt         (ps_gnt),
        .xb_gnt         (xb_gnt),
        .dm_gnt         (dm_gnt),
        .imm_gnt        (imm_gnt),
        .ps_bc_drr_sclt (ps_bc_drr_sclt),
        .ps_bc_di_sclt  (ps_bc_di_sclt),
        .bc_vld         (bc_vld),
        .bc_src         (bc_src)
    );

    assign obs = {dg_gnt, ps_gnt, xb_gnt, dm_gnt, imm_gnt,
                  ps_bc_drr_sclt, ps_bc_di_sclt, bc_vld, bc_src};

    task automatic model_eval();
        logic [2:0] r;
        logic [4:0] gv;
        logic       e_dm, e_imm, st;
        int         di, src, drr, idx;
        r     = {xb_req, ps_req, dg_req};
        m_g   = -1;
        m_dir = 1'b0;
        if (!rst_n) begin
            exp_v = {5'b0, 2'b11, 2'b11, 1'b0, 3'd0};
            return;
        end
        e_dm  = (m_pdr == 0) && !bc_hold && dm_req;
        e_imm = (m_pdr == 0) && !bc_hold && !dm_req && imm_req;
        m_dir = e_dm || e_imm;
        st    = (m_wt >= MAX_WAIT) && !m_dir;
        if (!bc_hold && !st) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_rr + k) % 3;
                if (m_g < 0 && r[idx]) m_g = idx;
            end
        end
        gv = 5'b0;
        if (m_g >= 0) gv[4-m_g] = 1'b1;
        gv[1] = e_dm;
        gv[0] = e_imm;
        drr = (m_g >= 0) ? m_g : 3;
        if (m_pdr != 0) begin
            di = 1; src = m_pdr;
        end else if (e_dm) begin
            di = 0; src = 4;
        end else if (e_imm) begin
            di = 2; src = 5;
        end else begin
            di = 3; src = 0;
        end
        exp_v = {gv, 2'(drr), 2'(di), (src != 0), 3'(src)};
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            m_pdr = 0; m_rr = 0; m_wt = 0;
        end else begin
            m_pdr = (m_g >= 0) ? m_g + 1 : 0;
            if (m_g >= 0) m_rr = (m_g + 1) % 3;
            if (m_dir || !(dm_req || imm_req)) m_wt = 0;
            else if (m_wt < WAIT_SAT) m_wt++;
        end
    endtask

    task automatic wait_neg();
        @(negedge clk_dcd);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk_dcd);
        model_commit();
        #1;
    endtask

    task automatic clear_reqs();
        bc_hold = 0; dg_req = 0; ps_req = 0; xb_req = 0; dm_req = 0; imm_req = 0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst_n = 0;
        wait_neg();
        advance();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int c = 0; c < 4; c++) begin
            {dg_req, ps_req, xb_req, dm_req, imm_req} = 5'($urandom);
            bc_hold = 1'($urandom);
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL reset c=%0d got %h exp %h", c, obs, exp_v);
            end
            n_vec++;
            if (bc_vld !== 1'b0 || ps_bc_di_sclt !== 2'b11) begin
                n_err++;
                $display("FAIL reset_idle c=%0d got vld=%b di=%b exp vld=0 di=11", c, bc_vld, ps_bc_di_sclt);
            end
            advance();
        end
        rst_n = 1;
        clear_reqs();
    endtask

    task automatic test_rotation();
        int es;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            dg_req = 1; ps_req = 1; xb_req = 1;
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rotation c=%0d got %h exp %h", c, obs, exp_v);
            end
            if (c < 4) begin
                n_vec++;
                if (ps_bc_drr_sclt !== 2'(c % 3)) begin
                    n_err++;
                    $display("FAIL rot_gnt c=%0d got %0d exp %0d", c, ps_bc_drr_sclt, c % 3);
                end
            end
            if (c >= 1 && c <= 4) begin
                es = ((c - 1) % 3) + 1;
                n_vec++;
                if (bc_src !== 3'(es) || ps_bc_di_sclt !== 2'b01) begin
                    n_err++;
                    $display("FAIL rot_src c=%0d got src=%0d di=%b exp src=%0d di=01", c, bc_src, ps_bc_di_sclt, es);
                end
            end
            advance();
        end
        clear_reqs();
    endtask

    task automatic test_direct();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            dm_req = 1; imm_req = 1;
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL direct c=%0d got %h exp %h", c, obs, exp_v);
            end
            n_vec++;
            if (dm_gnt !== 1'b1 || imm_gnt !== 1'b0 || ps_bc_di_sclt !== 2'b00) begin
                n_err++;
                $display("FAIL direct_dm c=%0d got dm=%b imm=%b di=%b exp 1 0 00", c, dm_gnt, imm_gnt, ps_bc_di_sclt);
            end
            advance();
        end
        clear_reqs();
    endtask

    task automatic test_pulse();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            ps_req = (c == 5);
            dm_req = (c == 5 || c == 6);
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL pulse c=%0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 5) begin
                n_vec++;
                if (dm_gnt !== 1'b1 || ps_gnt !== 1'b1) begin
                    n_err++;
                    $display("FAIL pulse_c5 got dm=%b ps=%b exp 1 1", dm_gnt, ps_gnt);
                end
            end
            if (c == 6) begin
                n_vec++;
                if (dm_gnt !== 1'b0 || bc_src !== 3'd2 || ps_bc_di_sclt !== 2'b01) begin
                    n_err++;
                    $display("FAIL pulse_c6 got dm=%b src=%0d di=%b exp 0 2 01", dm_gnt, bc_src, ps_bc_di_sclt);
                end
            end
            advance();
        end
        clear_reqs();
    endtask

    task automatic test_starve();
        do_reset();
        for (int c = 0; c < 19; c++) begin
            dg_req = 1; ps_req = 1; xb_req = 1;
            dm_req = (c >= 10 && c <= 15);
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL starve c=%0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 14) begin
                n_vec++;
                if (ps_bc_drr_sclt !== 2'b11 || dm_gnt !== 1'b0) begin
                    n_err++;
                    $display("FAIL starve_c14 got drr=%b dm=%b exp 11 0", ps_bc_drr_sclt, dm_gnt);
                end
            end
            if (c == 15) begin
                n_vec++;
                if (dm_gnt !== 1'b1 || ps_bc_di_sclt !== 2'b00 || ps_bc_drr_sclt === 2'b11) begin
                    n_err++;
                    $display("FAIL starve_c15 got dm=%b di=%b drr=%b exp 1 00 !=11", dm_gnt, ps_bc_di_sclt, ps_bc_drr_sclt);
                end
            end
            advance();
        end
        clear_reqs();
    endtask

    task automatic test_hold();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            xb_req  = (c == 2);
            bc_hold = (c >= 3 && c <= 5);
            dm_req  = (c >= 3);
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL hold c=%0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 3) begin
                n_vec++;
                if (bc_src !== 3'd3 || bc_vld !== 1'b1) begin
                    n_err++;
                    $display("FAIL hold_c3 got src=%0d vld=%b exp 3 1", bc_src, bc_vld);
                end
            end
            if (c == 4 || c == 5) begin
                n_vec++;
                if (ps_bc_di_sclt !== 2'b11 || dm_gnt !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_idle c=%0d got di=%b dm=%b exp 11 0", c, ps_bc_di_sclt, dm_gnt);
                end
            end
            advance();
        end
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            rst_n  = (c != 1);
            dg_req = 1;
            ps_req = (c >= 2);
            xb_req = (c >= 2);
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rstmid c=%0d got %h exp %h", c, obs, exp_v);
            end
            if (c == 1 || c == 2) begin
                n_vec++;
                if (bc_vld !== 1'b0) begin
                    n_err++;
                    $display("FAIL rstmid_vld c=%0d got %b exp 0", c, bc_vld);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (dg_gnt !== 1'b1 || ps_bc_drr_sclt !== 2'b00) begin
                    n_err++;
                    $display("FAIL rstmid_dg got dg=%b drr=%b exp 1 00", dg_gnt, ps_bc_drr_sclt);
                end
            end
            advance();
        end
        rst_n = 1;
        clear_reqs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 99) >= 3);
            bc_hold = ($urandom_range(0, 99) < 20);
            dg_req  = 1'($urandom);
            ps_req  = 1'($urandom);
            xb_req  = 1'($urandom);
            dm_req  = ($urandom_range(0, 99) < 30);
            imm_req = ($urandom_range(0, 99) < 30);
            wait_neg();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL random c=%0d got %h exp %h", c, obs, exp_v);
            end
            advance();
        end
        rst_n = 1;
        clear_reqs();
    endtask

    initial begin
        @(posedge clk_dcd);
        model_commit();
        #1;
        test_reset();
        test_rotation();
        test_direct();
        test_pulse();
        test_starve();
        test_hold();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
